fir_sample_feeder: RTL and testbench

Transmit-side driver for the FIR filter sample input handshake. Upstream logic writes samples into a small FIFO. The block presents one sample at a time on a valid/acknowledge interface, holds it stable until the filter pulses its ready, then pops it. A programmable inter-sample gap paces samples to emulate a fixed sample rate in front of the filter.

---
 rtl/fir_sample_feeder.sv | 139 +++++++++++++
 tb/tb_fir_sample_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// Sample FIFO plus valid/ready presenter feeding the FIR filter input.
// Samples are held stable until acknowledged, then an optional idle gap paces the next one.
module fir_sample_feeder #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_wr_en,
    input  logic [DATA_WIDTH-1:0]         iv_wr_data,
    output logic                          o_full,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   ov_level,
    output logic [DATA_WIDTH-1:0]         ov_dout,
    output logic                          o_dout_valid,
    input  logic                          i_ready,
    output logic [CNT_WIDTH-1:0]          ov_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_GAP     = 2'd2;

    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_overflow;

    logic [1:0]            r_state;
    logic                  r_valid;
    logic [GW-1:0]         r_gap_cnt;
    logic [CNT_WIDTH-1:0]  r_sent;

    logic                  w_wr_accept;
    logic                  w_pop;
    logic [LW-1:0]         w_level_nxt;

    assign w_wr_accept = i_wr_en && !r_full;
    // PRESENT is only entered with a non-empty FIFO and only a pop drains it, so no empty guard.
    assign w_pop       = (r_state == S_PRESENT) && i_en && i_ready;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_accept, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage is not reset; the empty-FIFO output mux hides stale contents.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= iv_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == FULL_LEVEL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_gap_cnt <= '0;
            r_sent    <= '0;
        end else if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    if (r_level != '0) begin
                        r_state <= S_PRESENT;
                        r_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_sent  <= r_sent + CNT_WIDTH'(1);
                        if (GAP_CYCLES > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - GW'(1);
                    if (r_gap_cnt == GW'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_full       = r_full;
    assign o_overflow   = r_overflow;
    assign ov_level     = r_level;
    assign ov_dout      = (r_level == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_dout_valid = r_valid;
    assign ov_sent      = r_sent;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: one instance without gap, one with a 4-cycle gap.
// Expected samples come from a scoreboard queue filled as writes are driven.
module tb_fir_sample_feeder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, wr0, rdy0, full0, ovf0, val0;
    logic [23:0] wd0, dout0;
    logic [4:0]  lvl0;
    logic [15:0] sent0;

    logic        rst4, en4, wr4, rdy4, full4, ovf4, val4;
    logic [23:0] wd4, dout4;
    logic [4:0]  lvl4;
    logic [15:0] sent4;

    fir_sample_feeder #(.DATA_WIDTH(24), .FIFO_DEPTH(16), .GAP_CYCLES(0), .CNT_WIDTH(16)) dut0 (
        .i_clk(clk), .i_rst(rst0), .i_en(en0), .i_wr_en(wr0), .iv_wr_data(wd0),
        .o_full(full0), .o_overflow(ovf0), .ov_level(lvl0), .ov_dout(dout0),
        .o_dout_valid(val0), .i_ready(rdy0), .ov_sent(sent0)
    );

    fir_sample_feeder #(.DATA_WIDTH(24), .FIFO_DEPTH(16), .GAP_CYCLES(4), .CNT_WIDTH(16)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_en(en4), .i_wr_en(wr4), .iv_wr_data(wd4),
        .o_full(full4), .o_overflow(ovf4), .ov_level(lvl4), .ov_dout(dout4),
        .o_dout_valid(val4), .i_ready(rdy4), .ov_sent(sent4)
    );

    // The filter may never acknowledge while the feeder is disabled.
    a_no_ack_when_disabled: assert property (@(posedge clk) !(rdy0 && !en0));

    typedef struct {
        logic [23:0] data;
        logic [4:0]  lvl;
        logic        full;
        logic        ovf;
    } vec_t;

    vec_t        tbl [17];
    logic [23:0] sb0 [$];
    int          sent_exp0;
    int          n_pass;
    int          n_checks;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write0(input logic [23:0] d);
        wr0 = 1'b1;
        wd0 = d;
        if (sb0.size() < 16) sb0.push_back(d);
        step();
        wr0 = 1'b0;
    endtask

    task automatic ack0(input string nm);
        logic [23:0] exp;
        for (int k = 0; k < 64 && !val0; k++) step();
        chk($sformatf("%s_valid", nm), {31'd0, val0}, 32'd1);
        if (val0 && sb0.size() > 0) begin
            exp = sb0.pop_front();
            chk($sformatf("%s_dout", nm), {8'd0, dout0}, {8'd0, exp});
            rdy0 = 1'b1;
            step();
            rdy0 = 1'b0;
            sent_exp0++;
            chk($sformatf("%s_valid_drop", nm), {31'd0, val0}, 32'd0);
            chk($sformatf("%s_sent", nm), {16'd0, sent0}, sent_exp0);
        end
    endtask

    task automatic reset_all();
        rst0 = 1'b1;
        rst4 = 1'b1;
        step();
        step();
        rst0 = 1'b0;
        rst4 = 1'b0;
        sb0.delete();
        sent_exp0 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_pass = 0;
        n_checks = 0;
        sent_exp0 = 0;
        rst0 = 1'b1; en0 = 1'b1; wr0 = 1'b0; wd0 = '0; rdy0 = 1'b0;
        rst4 = 1'b1; en4 = 1'b1; wr4 = 1'b0; wd4 = '0; rdy4 = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].data = 24'h100000 + 24'(i * 24'h000101);
            tbl[i].lvl  = 5'(i + 1);
            tbl[i].full = (i == 15);
            tbl[i].ovf  = 1'b0;
        end
        tbl[16].data = 24'hABCDEF;
        tbl[16].lvl  = 5'd16;
        tbl[16].full = 1'b1;
        tbl[16].ovf  = 1'b1;

        // Reset state and single held sample
        reset_all();
        chk("rst_valid", {31'd0, val0}, 0);
        chk("rst_full", {31'd0, full0}, 0);
        chk("rst_ovf", {31'd0, ovf0}, 0);
        chk("rst_level", {27'd0, lvl0}, 0);
        chk("rst_sent", {16'd0, sent0}, 0);
        chk("rst_dout", {8'd0, dout0}, 0);
        write0(24'h000001);
        chk("t1_level", {27'd0, lvl0}, 1);
        chk("t1_valid_lat0", {31'd0, val0}, 0);
        step();
        chk("t1_valid_lat1", {31'd0, val0}, 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_hold_dout%0d", i), {8'd0, dout0}, 32'h000001);
            chk($sformatf("t1_hold_valid%0d", i), {31'd0, val0}, 1);
            step();
        end
        chk("t1_sent", {16'd0, sent0}, 0);
        ack0("t1_ack");

        // Acknowledge while IDLE is ignored
        rdy0 = 1'b1;
        step();
        rdy0 = 1'b0;
        chk("idle_rdy_sent", {16'd0, sent0}, sent_exp0);
        chk("idle_rdy_level", {27'd0, lvl0}, 0);
        chk("idle_rdy_valid", {31'd0, val0}, 0);

        // No gap: three samples, one invalid cycle between them
        reset_all();
        write0(24'h000010);
        write0(24'h000020);
        write0(24'h000030);
        for (int i = 0; i < 3; i++) begin
            ack0($sformatf("g0_ack%0d", i));
            if (i < 2) begin
                step();
                chk($sformatf("g0_revalid%0d", i), {31'd0, val0}, 1);
            end
        end
        chk("g0_sent", {16'd0, sent0}, 3);
        chk("g0_level", {27'd0, lvl0}, 0);

        // Gap of 4: next valid appears after edge a+5; ready during GAP ignored
        wr4 = 1'b1;
        wd4 = 24'h000111;
        step();
        wd4 = 24'h000222;
        step();
        wr4 = 1'b0;
        chk("g4_valid", {31'd0, val4}, 1);
        chk("g4_dout0", {8'd0, dout4}, 32'h000111);
        rdy4 = 1'b1;
        step();
        rdy4 = 1'b0;
        chk("g4_drop", {31'd0, val4}, 0);
        chk("g4_sent1", {16'd0, sent4}, 1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) rdy4 = 1'b1;
            step();
            rdy4 = 1'b0;
            chk($sformatf("g4_gap%0d", k), {31'd0, val4}, 0);
            if (k == 2) begin
                chk("g4_gap_rdy_sent", {16'd0, sent4}, 1);
                chk("g4_gap_rdy_level", {27'd0, lvl4}, 1);
            end
        end
        step();
        chk("g4_revalid", {31'd0, val4}, 1);
        chk("g4_dout1", {8'd0, dout4}, 32'h000222);
        rdy4 = 1'b1;
        step();
        rdy4 = 1'b0;
        chk("g4_sent2", {16'd0, sent4}, 2);
        chk("g4_level", {27'd0, lvl4}, 0);

        // Fill, overflow, drop-with-pop, drain
        reset_all();
        for (int i = 0; i < 17; i++) begin
            write0(tbl[i].data);
            chk($sformatf("fill_level%0d", i), {27'd0, lvl0}, {27'd0, tbl[i].lvl});
            chk($sformatf("fill_full%0d", i), {31'd0, full0}, {31'd0, tbl[i].full});
            chk($sformatf("fill_ovf%0d", i), {31'd0, ovf0}, {31'd0, tbl[i].ovf});
        end
        chk("ovpop_valid", {31'd0, val0}, 1);
        if (sb0.size() > 0) begin
            chk("ovpop_dout", {8'd0, dout0}, {8'd0, sb0.pop_front()});
            wr0 = 1'b1;
            wd0 = 24'hABCDEF;
            rdy0 = 1'b1;
            step();
            wr0 = 1'b0;
            rdy0 = 1'b0;
            sent_exp0++;
            chk("ovpop_level", {27'd0, lvl0}, 15);
            chk("ovpop_full", {31'd0, full0}, 0);
            chk("ovpop_ovf", {31'd0, ovf0}, 1);
            chk("ovpop_sent", {16'd0, sent0}, sent_exp0);
        end
        for (int i = 0; i < 15; i++) ack0($sformatf("drain%0d", i));
        chk("drain_level", {27'd0, lvl0}, 0);
        chk("drain_full", {31'd0, full0}, 0);
        chk("drain_ovf", {31'd0, ovf0}, 1);
        chk("drain_sent", {16'd0, sent0}, 16);

        // Reset while PRESENT with three entries
        reset_all();
        write0(24'h0000A1);
        write0(24'h0000A2);
        write0(24'h0000A3);
        chk("mid_valid_pre", {31'd0, val0}, 1);
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        sb0.delete();
        sent_exp0 = 0;
        chk("mid_valid", {31'd0, val0}, 0);
        chk("mid_level", {27'd0, lvl0}, 0);
        chk("mid_sent", {16'd0, sent0}, 0);
        chk("mid_ovf", {31'd0, ovf0}, 0);
        chk("mid_dout", {8'd0, dout0}, 0);

        // Disabled: write still lands, FSM holds; PRESENT held while disabled
        en0 = 1'b0;
        write0(24'h7FFFFF);
        chk("en_level", {27'd0, lvl0}, 1);
        chk("en_valid0", {31'd0, val0}, 0);
        step();
        chk("en_valid1", {31'd0, val0}, 0);
        en0 = 1'b1;
        step();
        chk("en_valid2", {31'd0, val0}, 1);
        chk("en_dout", {8'd0, dout0}, 32'h7FFFFF);
        en0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("dis_hold_valid%0d", i), {31'd0, val0}, 1);
            chk($sformatf("dis_hold_sent%0d", i), {16'd0, sent0}, 0);
        end
        en0 = 1'b1;
        ack0("post_rst_ack");
        chk("post_rst_sent", {16'd0, sent0}, 1);
        chk("post_rst_level", {27'd0, lvl0}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
